// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM encoding,
// operation classification and the wait-counter width.
package mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_BAD
  } op_t;

  // Decide what an incoming request will do. Conflicting requests, unaligned
  // byte addresses and addresses beyond the storage depth are all rejected.
  function automatic op_t classify_op(input logic        rd,
                                      input logic        wr,
                                      input logic [31:0] a,
                                      input int          aw);
    logic [31:0] hi;
    hi = a >> (aw + 2);
    if (rd && wr)
      return OP_BAD;
    if ((a[1:0] != 2'b00) || (hi != 32'd0))
      return OP_BAD;
    return wr ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the controller datapath and the memory
// responder. The master drives requests; the slave returns completion.
interface mem_responder_if;

  logic        req_read;
  logic        req_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        error;
  logic        busy;

  modport master (
    output req_read, req_write, addr, wdata,
    input  rdata, ready, error, busy
  );

  modport slave (
    input  req_read, req_write, addr, wdata,
    output rdata, ready, error, busy
  );

endinterface

// File: rtl/mem_array.sv
// Word storage: synchronous write, asynchronous read, no reset so contents
// survive a reset of the surrounding control logic.
module mem_array #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Commit a word on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we)
      mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a word request, waits WAIT_CYCLES states,
// then performs the access on the edge entering RESP and pulses ready for
// one cycle. Rejected accesses complete with error and touch nothing.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  op_t                     op_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;

  logic                    accept;
  op_t                     op_in;
  logic [ADDR_WIDTH-1:0]   idx_in;

  logic                    entering_resp;
  op_t                     cm_op;
  logic [ADDR_WIDTH-1:0]   cm_idx;
  logic [31:0]             cm_wdata;
  logic                    mem_we;
  logic [31:0]             mem_rdata;

  assign accept = (state == IDLE) && (bus.req_read || bus.req_write);
  assign op_in  = classify_op(bus.req_read, bus.req_write, bus.addr, ADDR_WIDTH);
  assign idx_in = bus.addr[ADDR_WIDTH+1:2];

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt <= CNT_W'(1))
          state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The access happens on the edge entering RESP. With zero wait states that
  // edge is also the accept edge, so the live request is used instead of the
  // latched copy.
  always_comb begin
    entering_resp = (state_nxt == RESP) && (state != RESP);
    if (state == IDLE) begin
      cm_op    = op_in;
      cm_idx   = idx_in;
      cm_wdata = bus.wdata;
    end else begin
      cm_op    = op_q;
      cm_idx   = idx_q;
      cm_wdata = wdata_q;
    end
    // A write must not land while reset is held, even though the array has no reset.
    mem_we = entering_resp && (cm_op == OP_WRITE) && reset;
  end

  // State, counter and latched operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= OP_READ;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept)
        op_q <= op_in;
    end
  end

  // Address and write-data latches; pure data, captured on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= idx_in;
      wdata_q <= bus.wdata;
    end
  end

  // Read-data register: loads only when a valid read completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rdata_q <= '0;
    else if (entering_resp && (cm_op == OP_READ))
      rdata_q <= mem_rdata;
  end

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (cm_idx),
    .wdata (cm_wdata),
    .rdata (mem_rdata)
  );

  assign bus.rdata = rdata_q;
  assign bus.ready = (state == RESP);
  assign bus.error = (state == RESP) && (op_q == OP_BAD);
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with two wait states and
// one with none. Stimulus pushes expected completions; per-instance monitors
// pop and compare on every ready pulse.
module tb_mem_responder;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
    int          at;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  mem_responder_if ifa ();
  mem_responder_if ifb ();

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? ifa.ready : ifb.ready;
  endfunction

  task automatic drive(input int w, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (w == 0) begin
      ifa.req_read = rd; ifa.req_write = wr; ifa.addr = a; ifa.wdata = d;
    end else begin
      ifb.req_read = rd; ifb.req_write = wr; ifb.addr = a; ifb.wdata = d;
    end
  endtask

  task automatic push(input int w, input logic e, input logic c,
                      input logic [31:0] r, input int at);
    exp_t x;
    x.err = e; x.chk_rd = c; x.rd = r; x.at = at;
    if (w == 0) q_a.push_back(x);
    else        q_b.push_back(x);
  endtask

  // Wait (bounded) until the chosen instance shows ready at a falling edge.
  task automatic wait_ready(input int w, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(w) && n < 30);
    if (!rdy(w)) chk({name, " timeout"}, 32'd0, 32'd1);
  endtask

  // One complete access: call just after a rising edge.
  task automatic acc(input int w, input string name, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic e, input logic c, input logic [31:0] r);
    int lat;
    lat = (w == 0) ? 3 : 1;
    drive(w, rd, wr, a, d);
    push(w, e, c, r, cyc + lat);
    wait_ready(w, name);
    @(posedge clk);
    #1;
    drive(w, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Monitor for the two-wait-state instance.
  always @(negedge clk) begin
    if (reset && ifa.ready) begin
      if (q_a.size() == 0) begin
        chk("a unexpected ready", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = q_a.pop_front();
        chk("a error", {31'd0, ifa.error}, {31'd0, x.err});
        chk("a ready cycle", cyc, x.at);
        if (x.chk_rd) chk("a rdata", ifa.rdata, x.rd);
      end
    end
  end

  // Monitor for the zero-wait-state instance.
  always @(negedge clk) begin
    if (reset && ifb.ready) begin
      if (q_b.size() == 0) begin
        chk("b unexpected ready", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = q_b.pop_front();
        chk("b error", {31'd0, ifb.error}, {31'd0, x.err});
        chk("b ready cycle", cyc, x.at);
        if (x.chk_rd) chk("b rdata", ifb.rdata, x.rd);
      end
    end
  end

  initial begin
    int c0;
    cyc    = 0;
    checks = 0;
    errors = 0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rdata", ifa.rdata, 32'd0);
    chk("reset ready", {31'd0, ifa.ready}, 32'd0);
    chk("reset error", {31'd0, ifa.error}, 32'd0);
    chk("reset busy", {31'd0, ifa.busy}, 32'd0);
    chk("reset b busy", {31'd0, ifb.busy}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Basic write then read with two wait states.
    acc(0, "wr 10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    acc(0, "rd 10", 1'b1, 1'b0, 32'h10, 32'd0,        1'b0, 1'b1, 32'hDEADBEEF);
    // Misaligned read keeps rdata.
    acc(0, "rd 13", 1'b1, 1'b0, 32'h13, 32'd0,        1'b1, 1'b1, 32'hDEADBEEF);
    // Out-of-range write leaves word 0 untouched.
    acc(0, "wr 0",   1'b0, 1'b1, 32'h0,   32'h11111111, 1'b0, 1'b0, 32'd0);
    acc(0, "wr 400", 1'b0, 1'b1, 32'h400, 32'h00000BAD, 1'b1, 1'b1, 32'hDEADBEEF);
    acc(0, "rd 0",   1'b1, 1'b0, 32'h0,   32'd0,        1'b0, 1'b1, 32'h11111111);
    // Both requests together are rejected.
    acc(0, "both 10", 1'b1, 1'b1, 32'h10, 32'h00000055, 1'b1, 1'b1, 32'h11111111);
    acc(0, "rd 10b",  1'b1, 1'b0, 32'h10, 32'd0,        1'b0, 1'b1, 32'hDEADBEEF);

    // Reset during WAIT discards a pending write.
    acc(0, "wr 20", 1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    drive(0, 1'b0, 1'b1, 32'h20, 32'h0000AAAA);
    @(posedge clk);
    #1;
    chk("busy in wait", {31'd0, ifa.busy}, 32'd1);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("busy in reset", {31'd0, ifa.busy}, 32'd0);
    chk("ready in reset", {31'd0, ifa.ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    acc(0, "rd 20", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF);

    // Back-to-back: request held across ready.
    drive(0, 1'b1, 1'b0, 32'h0, 32'd0);
    c0 = cyc;
    push(0, 1'b0, 1'b1, 32'h11111111, c0 + 3);
    push(0, 1'b0, 1'b1, 32'h11111111, c0 + 7);
    wait_ready(0, "b2b first");
    @(negedge clk);
    chk("b2b busy gap", {31'd0, ifa.busy}, 32'd0);
    @(negedge clk);
    chk("b2b busy again", {31'd0, ifa.busy}, 32'd1);
    wait_ready(0, "b2b second");
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Zero wait states.
    acc(1, "b wr 04", 1'b0, 1'b1, 32'h04, 32'h12345678, 1'b0, 1'b0, 32'd0);
    acc(1, "b rd 04", 1'b1, 1'b0, 32'h04, 32'd0,        1'b0, 1'b1, 32'h12345678);
    acc(1, "b rd 13", 1'b1, 1'b0, 32'h13, 32'd0,        1'b1, 1'b1, 32'h12345678);

    repeat (4) @(posedge clk);
    #1;
    chk("a queue drained", q_a.size(), 32'd0);
    chk("b queue drained", q_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle CPU's memory port. It accepts word read/write requests from the controller datapath (the MemRead/MemWrite/address/write-data side) and completes each one after a fixed number of wait states. Completion is signalled with a one-cycle `ready` pulse and, on any rejected access, an `error` flag. It replaces the zero-latency memory so the controller can be exercised against a realistic, stalling memory.

## Interface
- `ADDR_WIDTH`, 8: word-address bits; storage depth is 2^ADDR_WIDTH words of 32 bits.
- `WAIT_CYCLES`, 2: wait states per access; legal range 0..15.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_read`  in  1  read request; held by the requester until `ready`.
- `req_write`  in  1  write request; held by the requester until `ready`.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data.
- `ready`  out  1  one-cycle completion pulse.
- `error`  out  1  qualified by `ready`; the access was rejected and no storage access took place.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Values of all outputs while `reset` is low: `rdata` = 0, `ready` = 0, `error` = 0, `busy` = 0, state IDLE, wait counter 0.
- Storage array contents are not cleared by reset.
- FSM states:
  - IDLE
  - WAIT: counter counts down from WAIT_CYCLES.
  - RESP: `ready` = 1.
- IDLE, with `req_read` or `req_write` high at the clock edge:
  - The block latches `addr`, `wdata` and the operation.
  - It classifies the access and moves to WAIT with counter = WAIT_CYCLES, or straight to RESP when WAIT_CYCLES = 0.
- An access is rejected, with `error` = 1 in RESP, when any of these holds:
  - both requests are high;
  - `addr[1:0]` != 0;
  - `addr[31:ADDR_WIDTH+2]` != 0.
- A rejected access never writes the array and leaves `rdata` unchanged.
- WAIT: the counter decrements once per cycle. On the edge where the counter equals 1, the state moves to RESP.
- The edge entering RESP:
  - A valid write commits the latched `wdata` to word `addr[ADDR_WIDTH+1:2]`.
  - A valid read loads `rdata` from that word.
- RESP lasts exactly one cycle, then the state returns to IDLE unconditionally. Request inputs are ignored during RESP.
- `rdata` holds its value until the next valid read completes.
- `error` is 0 in every cycle except a RESP cycle that carries a rejected access.
- Inputs that change during WAIT are ignored; only the latched values are used.

## Timing
- A request visible in cycle 0 is accepted at the end of cycle 0.
- `ready` is high in cycle WAIT_CYCLES + 1. With the default of 2, that is cycle 3.
- Handshake rule: the requester deasserts its request, or presents a new one, by the edge that ends the `ready` cycle.
- A request still asserted in the first IDLE cycle after RESP is treated as a new access, so back-to-back accesses are allowed.
- Throughput: one access per WAIT_CYCLES + 2 cycles.
- Reset asserted in WAIT discards the access. A write that has not reached the edge entering RESP leaves the array unchanged.
- Reset asserted in RESP forces `ready` low immediately. A write that has already committed stays committed.
- Reset asserted in IDLE with a request pending: the request is not accepted while reset is low. After reset is released it is accepted at the first edge.
- Read-after-write to the same word: the read returns the new data because the write commits before the read is accepted.

## Structure
- Package `mem_pkg` holds:
  - the state encoding: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  - the op enum: OP_READ, OP_WRITE, OP_BAD;
  - the width constant for the wait counter: 4 bits.
- Sub-module `mem_array`: 2^ADDR_WIDTH × 32 storage with a synchronous write port and an asynchronous read port. It has no reset.
- The top level holds the FSM, the wait counter, the request latches, address classification and the output registers.

## Test plan
- Basic write then read, WAIT_CYCLES = 2:
  - Write 0xDEADBEEF to 0x10 → `ready` in cycle 3 with `error` = 0.
  - Read 0x10 → `ready` in cycle 3 with `rdata` = 0xDEADBEEF.
- Zero wait states, WAIT_CYCLES = 0: write 0x12345678 to 0x04, then read 0x04 → each `ready` arrives in cycle 1; `rdata` = 0x12345678.
- Rejected accesses:
  - Read 0x13 (misaligned) → `ready` + `error`; `rdata` keeps its previous value.
  - Write to 0x400 with ADDR_WIDTH = 8 (out of range) → `error`; a read of 0x000 shows the word is unchanged.
- Both requests high together → `error` = 1; reads of the addressed word show no change.
- Reset mid-access:
  - Write 0x0000AAAA to 0x20, then pulse `reset` low in WAIT → `ready` never pulses.
  - A later read of 0x20 returns the prior value, 0xDEADBEEF.
  - `busy` = 0 while `reset` is low.
- Back-to-back: the request is held across `ready` → a second access is accepted in the next IDLE cycle; pulses are WAIT_CYCLES + 2 cycles apart; `busy` drops for exactly one cycle between them.
